angle_step_gen: RTL

- Parametrised angle sequencer that drives the radian/sine calculation path.
- Generates the next angle from a debounced touch press (manual mode) or from an internal rate divider (auto up, auto down, ping-pong modes).
- Each new angle goes out on a valid/ready handshake with a one-deep pending request.
- Reports wrap/reversal events, direction and debounce progress for board debug pins.

---
 rtl/angle_step_gen_if.sv | 11 +
 rtl/angle_step_gen.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/angle_step_gen_if.sv
// Angle output handshake between the sequencer and the radian/sine path.
interface angle_step_gen_if #(
  parameter int unsigned ANGLE_W = 32
);
  logic [ANGLE_W-1:0] angle_o;
  logic               angle_vld;
  logic               angle_rdy;

  modport master (output angle_o, output angle_vld, input angle_rdy);
  modport slave  (input angle_o, input angle_vld, output angle_rdy);
endinterface

// File: rtl/angle_step_gen.sv
// Angle sequencer: debounced manual stepping or divider-driven auto stepping,
// presented on a valid/ready handshake with a one-deep pending request.
module angle_step_gen #(
  parameter int unsigned ANGLE_W   = 32,
  parameter int unsigned STEP      = 100,
  parameter int unsigned ANGLE_MAX = 1000,
  parameter int unsigned DEB_CNT   = 8,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned AUTO_DIV  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             touch,
  input  logic [1:0]       mode,
  input  logic             hold,
  angle_step_gen_if.master bus,
  output logic             wrap_pulse,
  output logic             dir_o,
  output logic             drop_o,
  output logic [CNT_W-1:0] cnt_o
);

  localparam int unsigned AW1   = ANGLE_W + 1;
  localparam int unsigned DIV_W = $clog2(AUTO_DIV);

  localparam logic [1:0] M_MAN = 2'b00;
  localparam logic [1:0] M_UP  = 2'b01;
  localparam logic [1:0] M_DN  = 2'b10;
  localparam logic [1:0] M_PP  = 2'b11;

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t             state_q, state_d;
  logic [ANGLE_W-1:0] angle_q, angle_d;
  logic               vld_q, vld_d;
  logic               wrap_q, wrap_d;
  logic               dir_q, dir_d;
  logic               drop_q, drop_d;
  logic               pend_q, pend_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIV_W-1:0]   div_q, div_d;

  logic               press_c, auto_c, req_c, accept_c;
  logic [AW1-1:0]     a_ext_c, sum_up_c, dif_dn_c, wrap_dn_c;
  logic               up_bnd_c, dn_bnd_c, go_up_c;
  logic [ANGLE_W-1:0] nxt_angle_c;
  logic               nxt_wrap_c, nxt_dir_c;

  // Debounce: request only on the DEB_CNT-1 -> DEB_CNT transition, so one per press.
  always_comb begin
    cnt_d   = cnt_q;
    press_c = 1'b0;
    if (!touch) begin
      cnt_d = '0;
    end else if (cnt_q < CNT_W'(DEB_CNT)) begin
      cnt_d   = cnt_q + CNT_W'(1);
      press_c = (cnt_q == CNT_W'(DEB_CNT - 1));
    end
  end

  // Auto-rate divider; frozen by hold, cleared in manual mode.
  always_comb begin
    div_d  = div_q;
    auto_c = 1'b0;
    if (mode == M_MAN) begin
      div_d = '0;
    end else if (!hold) begin
      if (div_q == DIV_W'(AUTO_DIV - 1)) begin
        div_d  = '0;
        auto_c = 1'b1;
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  assign req_c    = auto_c | (press_c & (mode == M_MAN));
  assign accept_c = vld_q & bus.angle_rdy;

  // Next angle from the currently presented one, one bit wider to catch overflow.
  always_comb begin
    a_ext_c     = {1'b0, angle_q};
    sum_up_c    = a_ext_c + AW1'(STEP);
    dif_dn_c    = a_ext_c - AW1'(STEP);
    wrap_dn_c   = a_ext_c + AW1'(ANGLE_MAX) - AW1'(STEP);
    up_bnd_c    = (sum_up_c >= AW1'(ANGLE_MAX));
    dn_bnd_c    = (a_ext_c < AW1'(STEP));
    go_up_c     = (mode == M_MAN) || (mode == M_UP) || ((mode == M_PP) && dir_q);
    nxt_angle_c = ANGLE_W'(sum_up_c);
    nxt_wrap_c  = 1'b0;
    nxt_dir_c   = dir_q;
    if (mode == M_UP) nxt_dir_c = 1'b1;
    if (mode == M_DN) nxt_dir_c = 1'b0;
    if (go_up_c) begin
      if (up_bnd_c) begin
        nxt_wrap_c = 1'b1;
        if (mode == M_PP) begin
          nxt_angle_c = ANGLE_W'(dif_dn_c);
          nxt_dir_c   = 1'b0;
        end else begin
          nxt_angle_c = '0;
        end
      end
    end else begin
      nxt_angle_c = ANGLE_W'(dif_dn_c);
      if (dn_bnd_c) begin
        nxt_wrap_c = 1'b1;
        if (mode == M_PP) begin
          nxt_angle_c = ANGLE_W'(sum_up_c);
          nxt_dir_c   = 1'b1;
        end else begin
          nxt_angle_c = ANGLE_W'(wrap_dn_c);
        end
      end
    end
  end

  // Handshake FSM; a load always happens on the request or accept edge, never in between.
  always_comb begin
    state_d = state_q;
    angle_d = angle_q;
    vld_d   = vld_q;
    wrap_d  = 1'b0;
    dir_d   = dir_q;
    drop_d  = drop_q;
    pend_d  = pend_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_c) begin
          angle_d = nxt_angle_c;
          wrap_d  = nxt_wrap_c;
          dir_d   = nxt_dir_c;
          vld_d   = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (accept_c) begin
          if (pend_q || req_c) begin
            angle_d = nxt_angle_c;
            wrap_d  = nxt_wrap_c;
            dir_d   = nxt_dir_c;
            vld_d   = 1'b1;
            pend_d  = pend_q & req_c;
          end else begin
            vld_d   = 1'b0;
            state_d = S_IDLE;
          end
        end else if (req_c) begin
          if (pend_q) drop_d = 1'b1;
          else        pend_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      angle_q <= '0;
      vld_q   <= 1'b0;
      wrap_q  <= 1'b0;
      dir_q   <= 1'b1;
      drop_q  <= 1'b0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      angle_q <= angle_d;
      vld_q   <= vld_d;
      wrap_q  <= wrap_d;
      dir_q   <= dir_d;
      drop_q  <= drop_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
    end
  end

  assign bus.angle_o   = angle_q;
  assign bus.angle_vld = vld_q;
  assign wrap_pulse    = wrap_q;
  assign dir_o         = dir_q;
  assign drop_o        = drop_q;
  assign cnt_o         = cnt_q;

endmodule
